// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data bundle carrying one pipeline-stage payload between neighbouring stages.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 128
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: opaque payload, valid/ready handshake, optional skid entry,
// flush/enable control with bubble output, occupancy and saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH  = 128,
  parameter int unsigned      DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             flush,
  pipe_stage_reg_if.slave  in_bus,
  pipe_stage_reg_if.master out_bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic main_valid;
  logic skid_valid;
  logic live;
  logic in_ready;
  logic out_valid;
  logic accept;
  logic emit;

  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StFull);
  assign live       = enable && !flush;

  // Single-entry mode lets a same-cycle consume free the slot; skid mode keeps ready registered.
  if (DEPTH == 1) begin : g_single
    assign in_ready = live && !RST && (!main_valid || out_bus.ready);
  end else begin : g_skid
    assign in_ready = live && !RST && !skid_valid;
  end

  assign out_valid = live && main_valid;
  assign accept    = in_bus.valid && in_ready;
  assign emit      = out_valid && out_bus.ready;

  assign in_bus.ready  = in_ready;
  assign out_bus.valid = out_valid;
  assign out_bus.data  = main_valid ? main_q : BUBBLE;

  assign occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_count = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (enable) begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_bus.data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && emit) begin
            main_d = in_bus.data;
          end else if (accept && (DEPTH > 1)) begin
            skid_d  = in_bus.data;
            state_d = StFull;
          end else if (emit) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (emit) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_bus.ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StEmpty;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Payload storage carries no reset; emptiness is tracked solely by the state register.
  always_ff @(posedge CLK) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  a_no_accept_when_full: assert property (@(posedge CLK) disable iff (RST)
    !(accept && skid_valid));

  a_occupancy_bound: assert property (@(posedge CLK) disable iff (RST)
    occupancy <= 2'(DEPTH));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: two stage instances (skid and single-entry) driven by directed vectors.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_fl, b_en, b_fl;
  logic [1:0]  a_occ, b_occ;
  logic [15:0] a_stall;
  logic [3:0]  b_stall;

  pipe_stage_reg_if #(.WIDTH(16)) a_in ();
  pipe_stage_reg_if #(.WIDTH(16)) a_out ();
  pipe_stage_reg_if #(.WIDTH(16)) b_in ();
  pipe_stage_reg_if #(.WIDTH(16)) b_out ();

  pipe_stage_reg #(
    .WIDTH (16),
    .DEPTH (2),
    .BUBBLE(16'hDEAD),
    .CNT_W (16)
  ) u_a (
    .CLK        (clk),
    .RST        (rst),
    .enable     (a_en),
    .flush      (a_fl),
    .in_bus     (a_in),
    .out_bus    (a_out),
    .occupancy  (a_occ),
    .stall_count(a_stall)
  );

  pipe_stage_reg #(
    .WIDTH (16),
    .DEPTH (1),
    .BUBBLE(16'hBEEF),
    .CNT_W (4)
  ) u_b (
    .CLK        (clk),
    .RST        (rst),
    .enable     (b_en),
    .flush      (b_fl),
    .in_bus     (b_in),
    .out_bus    (b_out),
    .occupancy  (b_occ),
    .stall_count(b_stall)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] a_q[$];
  logic [15:0] b_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitors: every output handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && ((a_out.valid && a_out.ready) === 1'b1)) begin
      if (a_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra_emit got=%0h exp=none", a_out.data);
      end else begin
        check("a_order", {16'h0, a_out.data}, {16'h0, a_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ((b_out.valid && b_out.ready) === 1'b1)) begin
      if (b_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra_emit got=%0h exp=none", b_out.data);
      end else begin
        check("b_order", {16'h0, b_out.data}, {16'h0, b_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [15:0] d);
    bit got = 1'b0;
    a_in.valid = 1'b1;
    a_in.data  = d;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (a_in.ready) got = 1'b1;
      tick();
    end
    a_in.valid = 1'b0;
    check("a_send_accept", {31'h0, got}, 32'h1);
  endtask

  task automatic b_send(input logic [15:0] d);
    bit got = 1'b0;
    b_in.valid = 1'b1;
    b_in.data  = d;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (b_in.ready) got = 1'b1;
      tick();
    end
    b_in.valid = 1'b0;
    check("b_send_accept", {31'h0, got}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  bit         orp   [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  logic [1:0] occ_e [12] = '{0, 1, 1, 1, 2, 2, 2, 1, 1, 1, 1, 1};
  bit         rdy_e [12] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    int idx;
    int c0;
    bit acc;

    // Reset with upstream valid asserted.
    rst = 1'b1;
    a_en = 1'b1; a_fl = 1'b0; b_en = 1'b1; b_fl = 1'b0;
    a_in.valid = 1'b1; a_in.data = 16'hA5; a_out.ready = 1'b1;
    b_in.valid = 1'b1; b_in.data = 16'hA5; b_out.ready = 1'b1;
    tick();
    @(negedge clk);
    check("rst_a_in_ready", {31'h0, a_in.ready}, 32'h0);
    check("rst_a_out_valid", {31'h0, a_out.valid}, 32'h0);
    check("rst_a_occ", {30'h0, a_occ}, 32'h0);
    check("rst_a_bubble", {16'h0, a_out.data}, 32'hDEAD);
    check("rst_a_stall", {16'h0, a_stall}, 32'h0);
    check("rst_b_in_ready", {31'h0, b_in.ready}, 32'h0);
    check("rst_b_bubble", {16'h0, b_out.data}, 32'hBEEF);
    tick();
    @(negedge clk);
    check("rst2_a_occ", {30'h0, a_occ}, 32'h0);
    check("rst2_a_in_ready", {31'h0, a_in.ready}, 32'h0);
    tick();
    rst = 1'b0;
    a_in.valid = 1'b0;
    b_in.valid = 1'b0;
    @(negedge clk);
    check("post_rst_a_in_ready", {31'h0, a_in.ready}, 32'h1);
    check("post_rst_b_in_ready", {31'h0, b_in.ready}, 32'h1);
    tick();

    // Full-rate stream.
    for (int i = 1; i <= 8; i++) a_q.push_back(16'(i));
    c0 = cyc;
    for (int i = 1; i <= 8; i++) begin
      a_send(16'(i));
      check("stream_occ", {30'h0, a_occ}, 32'h1);
      check("stream_out_valid", {31'h0, a_out.valid}, 32'h1);
    end
    check("stream_cycles", 32'(cyc - c0), 32'd8);
    tick();
    check("stream_drained", {30'h0, a_occ}, 32'h0);

    // Backpressure for three cycles mid-stream.
    for (int i = 1; i <= 8; i++) a_q.push_back(16'(i));
    idx = 1;
    for (int c = 0; c < 12; c++) begin
      a_out.ready = orp[c];
      a_in.valid  = (idx <= 8);
      a_in.data   = 16'(idx);
      @(negedge clk);
      check("bp_in_ready", {31'h0, a_in.ready}, {31'h0, rdy_e[c]});
      check("bp_occ", {30'h0, a_occ}, {30'h0, occ_e[c]});
      acc = a_in.valid && a_in.ready;
      tick();
      if (acc) idx++;
    end
    a_in.valid = 1'b0;
    check("bp_all_accepted", 32'(idx), 32'd9);
    check("bp_stall", {16'h0, a_stall}, 32'd3);
    check("bp_drained", {30'h0, a_occ}, 32'h0);

    // Single-cycle flush with a full stage and a pending input.
    a_out.ready = 1'b0;
    a_send(16'h5);
    a_send(16'h6);
    check("fl_full", {30'h0, a_occ}, 32'h2);
    a_fl = 1'b1;
    a_in.valid = 1'b1;
    a_in.data = 16'h7;
    @(negedge clk);
    check("fl_in_ready", {31'h0, a_in.ready}, 32'h0);
    check("fl_out_valid", {31'h0, a_out.valid}, 32'h0);
    tick();
    a_fl = 1'b0;
    a_in.valid = 1'b0;
    a_out.ready = 1'b1;
    check("fl_occ", {30'h0, a_occ}, 32'h0);
    check("fl_out_valid_after", {31'h0, a_out.valid}, 32'h0);
    check("fl_bubble", {16'h0, a_out.data}, 32'hDEAD);
    check("fl_stall", {16'h0, a_stall}, 32'd4);

    // Multi-cycle flush, then accept on the first cycle with flush low.
    a_fl = 1'b1;
    a_in.valid = 1'b1;
    a_in.data = 16'h9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mfl_in_ready", {31'h0, a_in.ready}, 32'h0);
      check("mfl_occ", {30'h0, a_occ}, 32'h0);
      tick();
    end
    a_fl = 1'b0;
    a_q.push_back(16'h9);
    @(negedge clk);
    check("mfl_first_ready", {31'h0, a_in.ready}, 32'h1);
    tick();
    a_in.valid = 1'b0;
    check("mfl_occ1", {30'h0, a_occ}, 32'h1);
    tick();
    check("mfl_drained", {30'h0, a_occ}, 32'h0);

    // Freeze with one entry held.
    a_out.ready = 1'b0;
    a_q.push_back(16'h33);
    a_send(16'h33);
    a_en = 1'b0;
    a_in.valid = 1'b1;
    a_in.data = 16'h44;
    a_out.ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("frz_out_valid", {31'h0, a_out.valid}, 32'h0);
      check("frz_in_ready", {31'h0, a_in.ready}, 32'h0);
      check("frz_occ", {30'h0, a_occ}, 32'h1);
      check("frz_data", {16'h0, a_out.data}, 32'h33);
      tick();
    end
    a_en = 1'b1;
    a_in.valid = 1'b0;
    check("frz_stall", {16'h0, a_stall}, 32'd4);
    @(negedge clk);
    check("frz_release_valid", {31'h0, a_out.valid}, 32'h1);
    tick();
    check("frz_drained", {30'h0, a_occ}, 32'h0);
    tick();

    // Reset while full with a pending input.
    a_out.ready = 1'b0;
    a_send(16'h55);
    a_send(16'h66);
    check("rmid_full", {30'h0, a_occ}, 32'h2);
    rst = 1'b1;
    a_in.valid = 1'b1;
    a_in.data = 16'h77;
    tick();
    rst = 1'b0;
    a_in.valid = 1'b0;
    a_out.ready = 1'b1;
    check("rmid_occ", {30'h0, a_occ}, 32'h0);
    check("rmid_stall", {16'h0, a_stall}, 32'h0);
    check("rmid_bubble", {16'h0, a_out.data}, 32'hDEAD);
    tick();
    tick();

    // Single-entry instance: combinational ready, same-cycle replace, saturating stall.
    b_out.ready = 1'b0;
    b_send(16'h10);
    check("b_occ_full", {30'h0, b_occ}, 32'h1);
    b_in.valid = 1'b1;
    b_in.data = 16'h11;
    @(negedge clk);
    check("b_ready_blocked", {31'h0, b_in.ready}, 32'h0);
    tick();
    b_out.ready = 1'b1;
    b_q.push_back(16'h10);
    b_q.push_back(16'h11);
    @(negedge clk);
    check("b_ready_pass", {31'h0, b_in.ready}, 32'h1);
    check("b_out_valid", {31'h0, b_out.valid}, 32'h1);
    tick();
    b_in.valid = 1'b0;
    b_out.ready = 1'b0;
    check("b_replace_occ", {30'h0, b_occ}, 32'h1);
    check("b_stall_one", {28'h0, b_stall}, 32'h1);
    for (int c = 0; c < 20; c++) tick();
    check("b_stall_sat", {28'h0, b_stall}, 32'hF);
    b_out.ready = 1'b1;
    tick();
    check("b_drained", {30'h0, b_occ}, 32'h0);
    check("b_stall_hold", {28'h0, b_stall}, 32'hF);
    tick();
    tick();

    check("a_queue_empty", 32'(a_q.size()), 32'h0);
    check("b_queue_empty", 32'(b_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline-stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one elastic block carrying an opaque packed payload. It adds a valid/ready handshake, an optional two-entry skid buffer for full-throughput backpressure, and flush/enable control with bubble injection. It also provides occupancy and saturating stall-cycle outputs for the CPU tracker and performance counters. Each stage instantiates it with its own packed struct width.

## Interface
- WIDTH, 128: payload width in bits (packed stage struct).
- DEPTH, 2: entries; 1 = single register, ready combinationally passed back; 2 = main + skid register, registered ready.
- BUBBLE, '0: value driven on out_data while the stage is empty (NOP/bubble encoding).
- CNT_W, 16: stall counter width.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- enable  in  1  stage enable; 0 freezes contents (no accept, no emit).
- flush  in  1  discard all held entries at next edge.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  payload available downstream.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  head payload, BUBBLE when empty.
- occupancy  out  2  entries held (0..DEPTH).
- stall_count  out  CNT_W  saturating count of backpressured cycles.

## Operation
- accept = in_valid && in_ready; emit = out_valid && out_ready. Strict FIFO order; no loss or duplication.
- out_valid = enable && !flush && main_valid. out_data = main_valid ? main : BUBBLE, independent of enable.
- DEPTH=1: in_ready = enable && !flush && !RST && (!main_valid || out_ready). Simultaneous emit+accept replaces main.
- DEPTH=2: states EMPTY(0), ONE(1), FULL(2). in_ready = enable && !flush && !RST && !skid_valid (skid_valid is a register).
  - EMPTY: accept -> ONE (data to main).
  - ONE: accept && !emit -> FULL (data to skid); accept && emit -> ONE (data to main); emit only -> EMPTY.
  - FULL: emit -> ONE (skid moves to main, skid cleared); no accept possible.
- Priority: RST > flush > enable=0 > normal. flush: all entries invalidated next edge, no accept, no emit that cycle. enable=0: state held, handshakes both low.
- occupancy = main_valid + skid_valid (skid_valid always 0 for DEPTH=1).
- stall_count increments when enable && !flush && main_valid && !out_ready; saturates at 2^CNT_W-1; cleared only by RST.
- Payload registers need not be cleared on flush/reset; only valid bits are. Output must still show BUBBLE.

## Timing
- Latency in->out: 1 cycle (accepted at edge N, out_valid high in cycle after N).
- Throughput: 1 payload/cycle for both depths while out_ready is high.
- DEPTH=2 has no combinational path out_ready->in_ready; DEPTH=1 does.
- Reset values (cycle after RST sampled high): out_valid 0, out_data BUBBLE, occupancy 0, stall_count 0, in_ready 0 while RST high, = enable once RST low.
- RST mid-operation with FULL and in_valid high: next cycle occupancy 0, nothing captured.
- flush asserted for several cycles: stage stays EMPTY throughout; first accept possible in first cycle with flush low.

## Test plan
- Reset: RST high 2 cycles, in_valid=1, in_data=0xA5 -> in_ready 0, out_valid 0, occupancy 0, out_data=BUBBLE, stall_count 0.
- Stream (DEPTH=2): in_data 1..8 on consecutive cycles, out_ready=1 -> out_data 1..8 each one cycle later, no gaps, occupancy never exceeds 1.
- Backpressure: stream 1..8, out_ready low for 3 cycles mid-stream -> occupancy reaches 2, in_ready low while FULL, output sequence exactly 1..8, stall_count=3.
- Flush: occupancy 2 (payloads 5,6), in_valid=1 data 7, flush=1 one cycle -> next cycle occupancy 0, out_valid 0, out_data BUBBLE; 7 never emitted.
- Freeze: occupancy 1 (data 0x33), enable=0 for 4 cycles -> out_valid 0, in_ready 0, stall_count unchanged; enable=1 -> 0x33 emitted once.
- DEPTH=1, CNT_W=4: full, out_ready=1, in_valid=1 -> accept and emit same cycle; then out_ready=0 for 20 cycles -> stall_count saturates at 15.
